// File: rtl/divider_recon_mult_seq_pkg.sv
// Shared types and sizing for the shift-add dividend reconstructor (divider_recon_mult_seq).
package divrec_pkg;

  localparam int DIVREC_WIDTH_DEF  = 8;
  localparam int DIVREC_STEP_W_DEF = $clog2(DIVREC_WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divrec_state_e;

  // Step counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int divrec_step_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_recon_mult_seq_if.sv
// Valid/ready operand and result stream of the reconstructor.
// With DIVREC_CHECK_EN defined it also carries the reference dividend and the mismatch outputs.
interface divider_recon_mult_seq_if #(
  parameter int WIDTH = 8
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   q_in;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   r_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] n_out;
  logic               busy;
`ifdef DIVREC_CHECK_EN
  logic [2*WIDTH-1:0] n_ref;
  logic               mismatch;
  logic [15:0]        mismatch_cnt;

  modport master (
    output in_valid, q_in, d_in, r_in, out_ready, n_ref,
    input  in_ready, out_valid, n_out, busy, mismatch, mismatch_cnt
  );

  modport slave (
    input  in_valid, q_in, d_in, r_in, out_ready, n_ref,
    output in_ready, out_valid, n_out, busy, mismatch, mismatch_cnt
  );
`else
  modport master (
    output in_valid, q_in, d_in, r_in, out_ready,
    input  in_ready, out_valid, n_out, busy
  );

  modport slave (
    input  in_valid, q_in, d_in, r_in, out_ready,
    output in_ready, out_valid, n_out, busy
  );
`endif

endinterface

// File: rtl/divider_recon_mult_seq_add_step.sv
// One shift-add step of the reconstructor: add the aligned divisor when the current quotient bit is set.
module divrec_add_step #(
  parameter int NW = 16
) (
  input  logic [NW-1:0] acc_i,
  input  logic [NW-1:0] d_sh_i,
  input  logic          q_bit_i,
  output logic [NW-1:0] acc_o
);

  // The accumulator never exceeds 2^NW - 2^(NW/2), so no carry out is kept.
  assign acc_o = q_bit_i ? (acc_i + d_sh_i) : acc_i;

endmodule

// File: rtl/divider_recon_mult_seq.sv
// Sequential reconstructor n = q*d + r, LSB-first shift-add, one operand set in flight.
// Optional DIVREC_CHECK_EN adds a reference compare and a saturating mismatch counter.
//
// state | meaning
// IDLE  | ready for an operand set (in_ready=1)
// BUSY  | WIDTH shift-add steps, then one cycle to enter DONE
// DONE  | result held on n_out with out_valid until out_ready
module divider_recon_mult_seq
  import divrec_pkg::*;
#(
  parameter int WIDTH = DIVREC_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  divider_recon_mult_seq_if.slave  bus
);

  localparam int NW = 2 * WIDTH;
  localparam int SW = divrec_step_w(WIDTH);
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);

  divrec_state_e   state_q, state_d;
  logic [WIDTH-1:0] q_sh_q, q_sh_d;
  logic [NW-1:0]    d_sh_q, d_sh_d;
  logic [NW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    step_q, step_d;
  logic             fin_q, fin_d;
  logic [NW-1:0]    acc_step;
  logic             accept;
  logic             handoff;

  divrec_add_step #(.NW(NW)) u_add_step (
    .acc_i   (acc_q),
    .d_sh_i  (d_sh_q),
    .q_bit_i (q_sh_q[0]),
    .acc_o   (acc_step)
  );

  assign accept  = (state_q == IDLE) && bus.in_valid;
  assign handoff = (state_q == DONE) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_sh_q  <= '0;
      d_sh_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      d_sh_q  <= d_sh_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    d_sh_d  = d_sh_q;
    acc_d   = acc_q;
    step_d  = step_q;
    fin_d   = fin_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          q_sh_d  = bus.q_in;
          d_sh_d  = {{WIDTH{1'b0}}, bus.d_in};
          acc_d   = {{WIDTH{1'b0}}, bus.r_in};
          step_d  = '0;
          fin_d   = 1'b0;
        end
      end
      BUSY: begin
        // fin_q marks that all WIDTH steps are in; this cycle only moves to DONE.
        if (fin_q) begin
          state_d = DONE;
        end else begin
          acc_d  = acc_step;
          q_sh_d = q_sh_q >> 1;
          d_sh_d = d_sh_q << 1;
          step_d = step_q + SW'(1);
          if (step_q == STEP_LAST) begin
            fin_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (handoff) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.n_out     = (state_q == DONE) ? acc_q : '0;

`ifdef DIVREC_CHECK_EN
  logic [NW-1:0] n_ref_q;
  logic [15:0]   mm_cnt_q;
  logic          mm;

  assign mm = (state_q == DONE) && (acc_q != n_ref_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_ref_q  <= '0;
      mm_cnt_q <= '0;
    end else begin
      if (accept) begin
        n_ref_q <= bus.n_ref;
      end
      if (handoff && mm && (mm_cnt_q != 16'hFFFF)) begin
        mm_cnt_q <= mm_cnt_q + 16'd1;
      end
    end
  end

  assign bus.mismatch     = mm;
  assign bus.mismatch_cnt = mm_cnt_q;
`endif

endmodule

// File: tb/tb_divider_recon_mult_seq.sv
// Directed self-checking bench for divider_recon_mult_seq (reference/mismatch checks when DIVREC_CHECK_EN is defined).
module tb_divider_recon_mult_seq;

  localparam int W = 8;
  localparam int LAT = W + 1;
  localparam int TMO = 40;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   exp_cnt;

  divider_recon_mult_seq_if #(.WIDTH(W)) bus ();

  divider_recon_mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic drive(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                       input logic [2*W-1:0] nref);
    bus.q_in = q;
    bus.d_in = d;
    bus.r_in = r;
`ifdef DIVREC_CHECK_EN
    bus.n_ref = nref;
`else
    if (nref === 'x) bus.q_in = q;
`endif
  endtask

  // Full transaction: accept, latency, result, optional reference check, handoff.
  task automatic do_op(input string name, input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic [2*W-1:0] exp_n,
                       input logic [2*W-1:0] nref, input logic exp_mm);
    int cyc;
    drive(q, d, r, nref);
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready before accept: got %b want 1", name, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drive(~q, ~d, ~r, nref);
    wait_out(cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, LAT);
    end
    checks++;
    if (bus.n_out !== exp_n) begin
      errors++; $display("FAIL %s n_out: got %h want %h", name, bus.n_out, exp_n);
    end
`ifdef DIVREC_CHECK_EN
    checks++;
    if (bus.mismatch !== exp_mm) begin
      errors++; $display("FAIL %s mismatch: got %b want %b", name, bus.mismatch, exp_mm);
    end
    if (exp_mm) exp_cnt++;
`else
    if (exp_mm) exp_cnt++;
`endif
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handoff: got out_valid=%b in_ready=%b want 0/1",
                         name, bus.out_valid, bus.in_ready);
    end
`ifdef DIVREC_CHECK_EN
    checks++;
    if (bus.mismatch_cnt !== exp_cnt[15:0]) begin
      errors++; $display("FAIL %s mismatch_cnt: got %0d want %0d", name, bus.mismatch_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.n_out !== 16'h0000) begin
      errors++; $display("FAIL reset outputs: got out_valid=%b busy=%b n_out=%h want 0/0/0000",
                         bus.out_valid, bus.busy, bus.n_out);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready);
    end
`ifdef DIVREC_CHECK_EN
    checks++;
    if (bus.mismatch_cnt !== 16'd0 || bus.mismatch !== 1'b0) begin
      errors++; $display("FAIL reset check regs: got cnt=%0d mm=%b want 0/0", bus.mismatch_cnt, bus.mismatch);
    end
`endif
  endtask

  task automatic test_vectors();
    do_op("basic",  8'h05, 8'h0A, 8'h03, 16'h0035, 16'h0035, 1'b0);
    do_op("allff",  8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 1'b0);
    do_op("q_zero", 8'h00, 8'h7B, 8'h11, 16'h0011, 16'h0011, 1'b0);
    do_op("d_zero", 8'hAA, 8'h00, 8'h05, 16'h0005, 16'h0005, 1'b0);
    do_op("mixed",  8'h0C, 8'h0D, 8'h02, 16'h009E, 16'h009E, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    drive(8'h12, 8'h34, 8'h56, 16'h03FE);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(cyc);
    checks++;
    if (cyc !== LAT || bus.n_out !== 16'h03FE) begin
      errors++; $display("FAIL bp result: got lat=%0d n_out=%h want %0d/03fe", cyc, bus.n_out, LAT);
    end
    drive(8'h01, 8'h01, 8'h01, 16'h0002);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.n_out !== 16'h03FE || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp hold cycle %0d: got out_valid=%b n_out=%h in_ready=%b want 1/03fe/0",
                           i, bus.out_valid, bus.n_out, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp no stray accept: got busy=%b in_ready=%b out_valid=%b want 0/1/0",
                         bus.busy, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]   qv [3];
    logic [W-1:0]   dv [3];
    logic [W-1:0]   rv [3];
    logic [2*W-1:0] ev [3];
    int cyc;
    qv = '{8'h80, 8'h07, 8'h05};
    dv = '{8'h80, 8'h09, 8'h0A};
    rv = '{8'h01, 8'h00, 8'h03};
    ev = '{16'h4001, 16'h003F, 16'h0035};
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(qv[i], dv[i], rv[i], ev[i]);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b%0d in_ready: got %b want 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      drive(8'h33, 8'h33, 8'h33, 16'h0000);
      wait_out(cyc);
      checks++;
      if (cyc !== LAT || bus.n_out !== ev[i]) begin
        errors++; $display("FAIL b2b%0d result: got lat=%0d n_out=%h want %0d/%h", i, cyc, bus.n_out, LAT, ev[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b%0d bubble: got busy=%b in_ready=%b out_valid=%b want 0/1/0",
                           i, bus.busy, bus.in_ready, bus.out_valid);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int stray;
    drive(8'hFF, 8'hFF, 8'hFF, 16'hFF00);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.n_out !== 16'h0000) begin
      errors++; $display("FAIL midrst outputs: got busy=%b out_valid=%b n_out=%h want 0/0/0000",
                         bus.busy, bus.out_valid, bus.n_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL midrst aborted: got %0d active cycles want 0", stray);
    end
    do_op("after_rst", 8'h05, 8'h0A, 8'h03, 16'h0035, 16'h0035, 1'b0);
  endtask

  task automatic test_check_en();
    do_op("ref_bad",  8'h05, 8'h0A, 8'h03, 16'h0035, 16'h0036, 1'b1);
    do_op("ref_good", 8'h05, 8'h0A, 8'h03, 16'h0035, 16'h0035, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_cnt = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive('0, '0, '0, '0);
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
`ifdef DIVREC_CHECK_EN
    test_check_en();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
